// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, inverse-cipher FSM states, S-box tables
// and the GF(2^8) helpers used by the key schedule and round datapath.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    READY,
    ROUND,
    DONE
  } inv_cipher_state_e;

  // Entry n occupies bits [8n +: 8], so the first hex byte is entry 0.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TABLE[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_keyexp_iter.sv
// Iterative AES key expansion: latches the cipher key, then produces one
// expanded word per cycle into the round-key store, with a random-access read port.
module aes_keyexp_iter
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [0:Nk*32-1]          key,
  input  logic [$clog2(Nr+1)-1:0]   rd_round,
  output logic [0:AES_BLOCK_W-1]    rd_key,
  output logic                      last,
  output logic                      valid
);
  localparam int unsigned NW = 4 * (Nr + 1);
  localparam int unsigned IW = $clog2(Nr + 1) + 2;

  logic [31:0]   w_q [NW];
  logic [IW-1:0] cnt_q, cnt_d;
  logic [3:0]    pos_q, pos_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [31:0]   prev;
  logic [31:0]   word_d;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign last   = busy_q && (cnt_q == IW'(NW - 1));
  assign valid  = valid_q;
  assign rd_key = {w_q[{rd_round, 2'd0}], w_q[{rd_round, 2'd1}],
                   w_q[{rd_round, 2'd2}], w_q[{rd_round, 2'd3}]};

  // pos_q tracks i mod Nk and rnd_q tracks i / Nk without a divider.
  always_comb begin
    prev = w_q[cnt_q - IW'(1)];
    if (pos_q == '0) begin
      word_d = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(rnd_q), 24'h000000};
    end else if (Nk > 6 && pos_q == 4'd4) begin
      word_d = sub_word(prev);
    end else begin
      word_d = prev;
    end
    word_d = word_d ^ w_q[cnt_q - IW'(Nk)];
  end

  always_comb begin
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    if (load) begin
      cnt_d   = IW'(Nk);
      pos_d   = '0;
      rnd_d   = 4'd1;
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q + IW'(1);
      if (pos_q == 4'(Nk - 1)) begin
        pos_d = '0;
        rnd_d = rnd_q + 4'd1;
      end else begin
        pos_d = pos_q + 4'd1;
      end
      if (last) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned k = 0; k < Nk; k++) begin
        w_q[IW'(k)] <= key[k*32 +: 32];
      end
    end else if (busy_q) begin
      w_q[cnt_q] <= word_d;
    end
  end

endmodule

// File: rtl/inv_cipher.sv
// Iterative FIPS-197 inverse cipher: one registered round stage reused Nr times,
// fed by the iterative key schedule, with valid/ready handshakes on both sides.
module inv_cipher
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:Nk*32-1]       key,
  input  logic                   key_load,
  output logic                   key_ready,
  input  logic [0:AES_BLOCK_W-1] in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [0:AES_BLOCK_W-1] out,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int unsigned RW = $clog2(Nr + 1);

  inv_cipher_state_e      state_q, state_d;
  logic [0:AES_BLOCK_W-1] s_q, s_d;
  logic [RW-1:0]          round_q, round_d;
  logic [RW-1:0]          rk_sel;
  logic [0:AES_BLOCK_W-1] rk;
  logic [0:AES_BLOCK_W-1] round_out;
  logic                   ke_load, ke_last, ke_valid;

  function automatic logic [0:127] inv_shift_rows(input logic [0:127] a);
    logic [0:127] b;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        b[7'((c*4 + r)*8) +: 8] = a[7'(((((c + 4 - r) % 4))*4 + r)*8) +: 8];
      end
    end
    return b;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] a);
    logic [0:127] b;
    for (int unsigned n = 0; n < 16; n++) begin
      b[7'(n*8) +: 8] = inv_sbox(a[7'(n*8) +: 8]);
    end
    return b;
  endfunction

  // {0e},{0b},{0d},{09} are built from the x2/x4/x8 xtime chain of each byte.
  function automatic logic [0:127] inv_mix_columns(input logic [0:127] a);
    logic [0:127] b;
    logic [7:0] x [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        x[r]  = a[7'((c*4 + r)*8) +: 8];
        x2[r] = xtime(x[r]);
        x4[r] = xtime(x2[r]);
        x8[r] = xtime(x4[r]);
        m9[r] = x8[r] ^ x[r];
        mb[r] = x8[r] ^ x2[r] ^ x[r];
        md[r] = x8[r] ^ x4[r] ^ x[r];
        me[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      for (int unsigned r = 0; r < 4; r++) begin
        b[7'((c*4 + r)*8) +: 8] = me[r] ^ mb[2'((r + 1) % 4)]
                                ^ md[2'((r + 2) % 4)] ^ m9[2'((r + 3) % 4)];
      end
    end
    return b;
  endfunction

  assign ke_load   = key_load && (state_q == IDLE || state_q == READY);
  assign key_ready = (state_q == READY) || (state_q == ROUND) || (state_q == DONE);
  assign in_ready  = (state_q == READY) && !key_load && ke_valid;
  assign out_valid = (state_q == DONE);
  assign out       = out_valid ? s_q : '0;

  aes_keyexp_iter #(.Nk(Nk), .Nr(Nr)) u_keyexp (
    .clk      (clk),
    .rst      (rst),
    .load     (ke_load),
    .key      (key),
    .rd_round (rk_sel),
    .rd_key   (rk),
    .last     (ke_last),
    .valid    (ke_valid)
  );

  // The single key read port serves rk[Nr] on acceptance and rk[round] afterwards.
  always_comb begin
    rk_sel    = (state_q == ROUND) ? round_q : RW'(Nr);
    round_out = inv_sub_bytes(inv_shift_rows(s_q)) ^ rk;
    if (round_q != '0) begin
      round_out = inv_mix_columns(round_out);
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    round_d = round_q;
    case (state_q)
      IDLE:   if (key_load) state_d = KEYEXP;
      KEYEXP: if (ke_last) state_d = READY;
      READY: begin
        if (key_load) begin
          state_d = KEYEXP;
        end else if (in_valid && in_ready) begin
          s_d     = in ^ rk;
          round_d = RW'(Nr - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        s_d = round_out;
        if (round_q == '0) state_d = DONE;
        else round_d = round_q - RW'(1);
      end
      DONE:   if (out_ready) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_inv_cipher.sv
// Self-checking bench for inv_cipher: AES-128 and AES-256 instances, known-answer
// vectors through a plaintext scoreboard, handshake, key-reload and reset scenarios.
module tb_inv_cipher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [0:127] key_a;
  logic         key_load_a, key_ready_a;
  logic [0:127] in_a, out_a;
  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [0:255] key_b;
  logic         key_load_b, key_ready_b;
  logic [0:127] in_b, out_b;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;

  inv_cipher #(.Nk(4), .Nr(10)) dut_a (
    .clk(clk), .rst(rst), .key(key_a), .key_load(key_load_a), .key_ready(key_ready_a),
    .in(in_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  inv_cipher #(.Nk(8), .Nr(14)) dut_b (
    .clk(clk), .rst(rst), .key(key_b), .key_load(key_load_b), .key_ready(key_ready_b),
    .in(in_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  localparam logic [0:127] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:255] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:127] PT3  = 128'h00112233445566778899aabbccddeeff;

  int unsigned  tests_run = 0;
  int unsigned  tests_failed = 0;
  logic [0:127] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key_a(input logic [0:127] k, input string tag);
    int n;
    key_a      = k;
    key_load_a = 1'b1;
    step();
    key_load_a = 1'b0;
    n = 0;
    while (key_ready_a !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    tests_run++;
    if (n != 40) begin
      tests_failed++;
      $display("FAIL %s key_ready latency: got %0d cycles, expected 40", tag, n);
    end
  endtask

  task automatic decrypt_a(input logic [0:127] ct, input logic [0:127] pt,
                           input int stall, input string tag);
    int n;
    logic [0:127] exp_pt, held;
    n = 0;
    while (in_ready_a !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    in_a = ct;
    in_valid_a = 1'b1;
    tests_run++;
    if (in_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s in_ready: got %b, expected 1", tag, in_ready_a);
    end
    step();
    in_valid_a = 1'b0;
    exp_q.push_back(pt);
    n = 0;
    while (out_valid_a !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    tests_run++;
    if (n != 10) begin
      tests_failed++;
      $display("FAIL %s out_valid latency: got %0d cycles, expected 10", tag, n);
    end
    exp_pt = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    tests_run++;
    if (out_a !== exp_pt) begin
      tests_failed++;
      $display("FAIL %s plaintext: got %h, expected %h", tag, out_a, exp_pt);
    end
    held = out_a;
    in_a = CT1;
    if (stall > 0) in_valid_a = 1'b1;
    for (int i = 0; i < stall; i++) begin
      step();
      tests_run++;
      if (out_valid_a !== 1'b1 || out_a !== held || in_ready_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s stall cycle %0d: out_valid=%b in_ready=%b out=%h, expected 1/0/%h",
                 tag, i, out_valid_a, in_ready_a, out_a, held);
      end
    end
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
    if (stall > 0) begin
      tests_run++;
      if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s after release: out_valid=%b in_ready=%b, expected 0/1",
                 tag, out_valid_a, in_ready_a);
      end
      in_valid_a = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    key_load_a = 1'b1;
    in_valid_a = 1'b1;
    out_ready_a = 1'b1;
    step();
    key_load_a = 1'b0;
    in_valid_a = 1'b0;
    out_ready_a = 1'b0;
    tests_run++;
    if (key_ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset key_ready: got %b, expected 0", key_ready_a);
    end
    tests_run++;
    if (in_ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset in_ready: got %b, expected 0", in_ready_a);
    end
    tests_run++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset out_valid: got %b/%b, expected 0/0", out_valid_a, out_valid_b);
    end
    tests_run++;
    if (out_a !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset out: got %h, expected 0", out_a);
    end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (key_ready_a !== 1'b0) n++;
    end
    tests_run++;
    if (n != 0) begin
      tests_failed++;
      $display("FAIL reset priority: key_ready high %0d cycles, expected 0", n);
    end
  endtask

  task automatic test_aes128_vectors();
    load_key_a(KEY1, "kat1_key");
    decrypt_a(CT1, PT1, 0, "kat1");
    load_key_a(KEY2, "kat2_key");
    decrypt_a(CT2, PT2, 0, "kat2");
  endtask

  task automatic test_backpressure();
    decrypt_a(CT2, PT2, 5, "backpressure");
  endtask

  task automatic test_key_load_priority();
    in_a       = CT2;
    in_valid_a = 1'b1;
    key_a      = KEY1;
    key_load_a = 1'b1;
    #1;
    tests_run++;
    if (in_ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL keyload_prio in_ready: got %b, expected 0", in_ready_a);
    end
    load_key_a(KEY1, "keyload_prio_key");
    in_valid_a = 1'b0;
    decrypt_a(CT1, PT1, 0, "keyload_prio");
  endtask

  task automatic test_aes256();
    int n;
    logic [0:127] exp_pt;
    key_b      = KEY3;
    key_load_b = 1'b1;
    step();
    key_load_b = 1'b0;
    n = 0;
    while (key_ready_b !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    tests_run++;
    if (n != 52) begin
      tests_failed++;
      $display("FAIL aes256 key_ready latency: got %0d cycles, expected 52", n);
    end
    in_b       = CT3;
    in_valid_b = 1'b1;
    tests_run++;
    if (in_ready_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL aes256 in_ready: got %b, expected 1", in_ready_b);
    end
    step();
    in_valid_b = 1'b0;
    exp_q.push_back(PT3);
    n = 0;
    while (out_valid_b !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    tests_run++;
    if (n != 14) begin
      tests_failed++;
      $display("FAIL aes256 out_valid latency: got %0d cycles, expected 14", n);
    end
    exp_pt = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    tests_run++;
    if (out_b !== exp_pt) begin
      tests_failed++;
      $display("FAIL aes256 plaintext: got %h, expected %h", out_b, exp_pt);
    end
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    int seen_ov, seen_ir, seen_kr;
    in_a       = CT1;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    exp_q.push_back(PT1);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    seen_ov = 0;
    seen_ir = 0;
    seen_kr = 0;
    in_valid_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid_a !== 1'b0) seen_ov++;
      if (in_ready_a !== 1'b0) seen_ir++;
      if (key_ready_a !== 1'b0) seen_kr++;
      step();
    end
    in_valid_a = 1'b0;
    tests_run++;
    if (seen_ov != 0) begin
      tests_failed++;
      $display("FAIL midround_rst out_valid: high %0d cycles, expected 0", seen_ov);
    end
    tests_run++;
    if (seen_ir != 0 || seen_kr != 0) begin
      tests_failed++;
      $display("FAIL midround_rst ready: in_ready %0d / key_ready %0d cycles, expected 0/0",
               seen_ir, seen_kr);
    end
    load_key_a(KEY1, "midround_rst_key");
    decrypt_a(CT1, PT1, 0, "midround_rst");
  endtask

  initial begin
    rst = 1'b1;
    key_a = '0; key_load_a = 1'b0; in_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    key_b = '0; key_load_b = 1'b0; in_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    test_reset();
    test_aes128_vectors();
    test_backpressure();
    test_key_load_priority();
    test_aes256();
    test_reset_mid_round();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
